// File: rtl/pn_gen_pkg.sv
// Shared state type and maximal-length default feedback masks for the PN generator.
package pn_gen_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} pn_state_e;

    localparam int PN_MIN_W = 3;
    localparam int PN_MAX_W = 16;

    // Fibonacci masks: bit k set means stage k feeds the XOR (x^7+x^6+1 -> 'h60).
    function automatic logic [PN_MAX_W-1:0] pn_default_taps(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/pn_lfsr_core.sv
// One Fibonacci LFSR: captures seed/taps on load, shifts left on adv.
// Reports its MSB and whether the current state equals the captured seed.
module pn_lfsr_core #(
    parameter int             W        = 7,
    parameter logic [W-1:0]   RST_SEED = '1,
    parameter logic [W-1:0]   RST_TAPS = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         adv,
    input  logic [W-1:0] seed,
    input  logic [W-1:0] taps,
    output logic         msb,
    output logic         at_seed
);

    logic [W-1:0] lfsr;
    logic [W-1:0] taps_reg;
    logic [W-1:0] seed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= RST_SEED;
            taps_reg <= RST_TAPS;
            seed_reg <= RST_SEED;
        end else if (load) begin
            lfsr     <= seed;
            taps_reg <= taps;
            seed_reg <= seed;
        end else if (adv) begin
            lfsr <= {lfsr[W-2:0], ^(lfsr & taps_reg)};
        end
    end

    assign msb     = lfsr[W-1];
    assign at_seed = (lfsr == seed_reg);

endmodule

// File: rtl/pn_gen_param.sv
// PN chip generator: Fibonacci LFSR behind a chip-rate divider, with epoch marker.
// Define PN_GOLD_CODE_EN to add seed2/taps2 and a second LFSR for gold-code chips.
module pn_gen_param
    import pn_gen_pkg::*;
#(
    parameter int                LFSR_W       = 7,
    parameter int                CHIP_DIV     = 1,
    parameter logic [LFSR_W-1:0] DEFAULT_TAPS = LFSR_W'(pn_default_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LFSR_W-1:0] taps,
`ifdef PN_GOLD_CODE_EN
    input  logic [LFSR_W-1:0] seed2,
    input  logic [LFSR_W-1:0] taps2,
`endif
    output logic              pn,
    output logic              pn_valid,
    output logic              epoch,
    output logic              seed_err
);

`ifdef PN_GOLD_CODE_EN
    localparam int NUM_LFSR = 2;
`else
    localparam int NUM_LFSR = 1;
`endif
    localparam int              CNT_W    = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHIP_DIV - 1);

    logic [NUM_LFSR-1:0][LFSR_W-1:0] seed_v;
    logic [NUM_LFSR-1:0][LFSR_W-1:0] taps_v;
    logic [NUM_LFSR-1:0]             seed_nz;
    logic [NUM_LFSR-1:0]             msb;
    logic [NUM_LFSR-1:0]             at_seed;

    pn_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             seed_ok;
    logic             accept;
    logic             step;
    logic             adv;

`ifdef PN_GOLD_CODE_EN
    assign seed_v = {seed2, seed};
    assign taps_v = {taps2, taps};
`else
    assign seed_v = seed;
    assign taps_v = taps;
`endif

    // Any load blocks stepping, so a rejected seed also freezes the divider.
    assign seed_ok = &seed_nz;
    assign accept  = load & seed_ok;
    assign step    = (state == RUN) & en & ~load;
    assign adv     = step & (cnt == CNT_LAST);

    for (genvar i = 0; i < NUM_LFSR; i++) begin : g_lfsr
        assign seed_nz[i] = |seed_v[i];

        pn_lfsr_core #(
            .W        (LFSR_W),
            .RST_SEED (DEFAULT_SEED),
            .RST_TAPS (DEFAULT_TAPS)
        ) u_core (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (accept),
            .adv     (adv),
            .seed    (seed_v[i]),
            .taps    (taps_v[i]),
            .msb     (msb[i]),
            .at_seed (at_seed[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pn       <= 1'b0;
            pn_valid <= 1'b0;
            epoch    <= 1'b0;
            seed_err <= 1'b0;
        end else begin
            pn_valid <= adv;
            epoch    <= adv & (&at_seed);
            seed_err <= load & ~seed_ok;
            if (adv)
                pn <= ^msb;
            if (accept) begin
                state <= RUN;
                cnt   <= '0;
            end else if (step) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pn_gen_param.sv
// Self-checking bench for pn_gen_param: chip-level model plus directed literal checks.
module tb_pn_gen_param;
    import pn_gen_pkg::*;

    localparam int             W     = 7;
    localparam logic [W-1:0]   DTAPS = 7'b1100000;
`ifdef PN_GOLD_CODE_EN
    localparam bit GOLD = 1'b1;
`else
    localparam bit GOLD = 1'b0;
`endif

    typedef struct {
        bit run;
        int cnt;
        int s1, s2, sd1, sd2, tp1, tp2;
        bit pn, pv, ep, se;
    } mdl_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] seed = '0;
    logic [W-1:0] taps = DTAPS;
    logic [W-1:0] seed2 = 7'h01;
    logic [W-1:0] taps2 = DTAPS;
    logic d1_pn, d1_pv, d1_ep, d1_se;
    logic d4_pn, d4_pv, d4_ep, d4_se;
    int   total = 0;
    int   bad = 0;
    mdl_t m1 = '{default: 0};
    mdl_t m4 = '{default: 0};

    always #5 clk = ~clk;

    pn_gen_param #(.LFSR_W(W), .CHIP_DIV(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed), .taps(taps),
`ifdef PN_GOLD_CODE_EN
        .seed2(seed2), .taps2(taps2),
`endif
        .pn(d1_pn), .pn_valid(d1_pv), .epoch(d1_ep), .seed_err(d1_se)
    );

    pn_gen_param #(.LFSR_W(W), .CHIP_DIV(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed), .taps(taps),
`ifdef PN_GOLD_CODE_EN
        .seed2(seed2), .taps2(taps2),
`endif
        .pn(d4_pn), .pn_valid(d4_pv), .epoch(d4_ep), .seed_err(d4_se)
    );

`ifdef PN_GOLD_CODE_EN
    logic [4:0] gseed = 5'd1, gtaps = 5'b10100, gseed2 = 5'd1, gtaps2 = 5'b11110;
    logic g_pn, g_pv, g_ep, g_se;
    mdl_t mg = '{default: 0};

    pn_gen_param #(.LFSR_W(5), .CHIP_DIV(1)) u_g (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(gseed), .taps(gtaps),
        .seed2(gseed2), .taps2(gtaps2),
        .pn(g_pn), .pn_valid(g_pv), .epoch(g_ep), .seed_err(g_se)
    );
`endif

    function automatic int nxt(input int s, input int t, input int w);
        return ((s << 1) | ($countones(s & t) & 1)) & ((1 << w) - 1);
    endfunction

    // Chip-level reference: count enabled cycles, emit a chip every div of them.
    task automatic mstep(inout mdl_t m, input int w, input int div, input bit gold,
                         input bit e, input bit ld, input int sd1, input int tp1,
                         input int sd2, input int tp2);
        m.pv = 0; m.ep = 0; m.se = 0;
        if (ld) begin
            if (sd1 == 0 || (gold && sd2 == 0)) begin
                m.se = 1;
            end else begin
                m.run = 1; m.cnt = 0;
                m.s1 = sd1; m.sd1 = sd1; m.tp1 = tp1;
                m.s2 = sd2; m.sd2 = sd2; m.tp2 = tp2;
            end
        end else if (m.run && e) begin
            m.cnt++;
            if (m.cnt == div) begin
                m.cnt = 0;
                m.pv  = 1;
                m.pn  = m.s1[w-1] ^ (gold & m.s2[w-1]);
                m.ep  = (m.s1 == m.sd1) && (!gold || m.s2 == m.sd2);
                m.s1  = nxt(m.s1, m.tp1, w);
                m.s2  = nxt(m.s2, m.tp2, w);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 = '{default: 0};
            m4 = '{default: 0};
`ifdef PN_GOLD_CODE_EN
            mg = '{default: 0};
`endif
        end else begin
            mstep(m1, W, 1, GOLD, en, load, int'(seed), int'(taps), int'(seed2), int'(taps2));
            mstep(m4, W, 4, GOLD, en, load, int'(seed), int'(taps), int'(seed2), int'(taps2));
`ifdef PN_GOLD_CODE_EN
            mstep(mg, 5, 1, 1'b1, en, load, int'(gseed), int'(gtaps), int'(gseed2), int'(gtaps2));
`endif
        end
    end

    always @(negedge clk) begin
        chk("d1_out", {d1_pn, d1_pv, d1_ep, d1_se}, {m1.pn, m1.pv, m1.ep, m1.se});
        chk("d4_out", {d4_pn, d4_pv, d4_ep, d4_se}, {m4.pn, m4.pv, m4.ep, m4.se});
`ifdef PN_GOLD_CODE_EN
        chk("g_out", {g_pn, g_pv, g_ep, g_se}, {mg.pn, mg.pv, mg.ep, mg.se});
`endif
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int       cnt, idx, first, n;
        logic [7:0] chips;
        logic     pn_hold, got;
        int       epq[$];
        int       gq[$];
        int       gidx;

        repeat (2) @(negedge clk);
        chk("rst_d1", {d1_pn, d1_pv, d1_ep, d1_se}, 0);
        chk("rst_d4", {d4_pn, d4_pv, d4_ep, d4_se}, 0);
        #2 rst_n = 1'b1;

        // Idle after reset: no chips without a load
        en = 1'b1; cnt = 0;
        repeat (6) begin @(negedge clk); cnt += d1_pv + d4_pv; end
        chk("idle_no_pv", cnt, 0);

        // All-zero seed is rejected
        seed = '0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("zero_seed_err", d1_se, 1);
        chk("zero_seed_pv", d1_pv, 0);
        @(negedge clk);
        chk("zero_seed_1cyc", d1_se, 0);
        cnt = 0;
        repeat (8) begin @(negedge clk); cnt += d1_pv + d4_pv; end
        chk("zero_seed_idle", cnt, 0);

        // Default taps from all-ones seed, CHIP_DIV=1
        seed = 7'h7F; taps = DTAPS; load = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("load_cycle_pv", d1_pv, 0);
        idx = 0; first = -1; chips = '0; gidx = 0;
        for (int i = 0; i < 258; i++) begin
            @(negedge clk);
            if (d1_pv) begin
                if (first < 0) first = i;
                if (idx < 8) chips[7-idx] = d1_pn;
                if (d1_ep) epq.push_back(idx);
                idx++;
            end
`ifdef PN_GOLD_CODE_EN
            if (g_pv) begin
                if (g_ep) gq.push_back(gidx);
                gidx++;
            end
`endif
        end
        chk("first_chip_lat", first, 0);
        chk("chip_count", idx, 258);
`ifndef PN_GOLD_CODE_EN
        chk("first8", chips, 8'hFE);
`endif
        chk("epoch_n", epq.size(), 3);
        for (int k = 0; k < 3; k++)
            chk("epoch_idx", (k < epq.size()) ? epq[k] : -1, k * 127);
`ifdef PN_GOLD_CODE_EN
        chk("gold_period", (gq.size() > 1) ? gq[1] - gq[0] : -1, 31);
`endif

        // CHIP_DIV=4 with en low mid-chip
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin @(negedge clk); got = d4_pv; end
        chk("div4_sync", got, 1);
        pn_hold = d4_pn;
        @(negedge clk); en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("div4_hold_pn", d4_pn, pn_hold);
            chk("div4_hold_pv", d4_pv, 0);
        end
        en = 1'b1; n = 0; got = 1'b0;
        while (!got && n < 10) begin @(negedge clk); n++; got = d4_pv; end
        chk("div4_gap", n, 3);

        // Load on an advance cycle wins; next chip restarts from the seed
        @(negedge clk); seed = 7'h2A; load = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("ld_adv_pv", d1_pv, 0);
        @(negedge clk);
        chk("ld_adv_next", {d1_pv, d1_pn, d1_ep}, 3'b101);

        // Reset at chip 50 discards the sequence
        @(negedge clk); seed = 7'h7F; load = 1'b1;
        @(negedge clk); load = 1'b0;
        idx = 0;
        for (int i = 0; i < 60 && idx < 50; i++) begin @(negedge clk); idx += d1_pv; end
        chk("chip50", idx, 50);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_d1", {d1_pn, d1_pv, d1_ep, d1_se}, 0);
        chk("rst_async_d4", {d4_pn, d4_pv, d4_ep, d4_se}, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); cnt += d1_pv + d4_pv; end
        chk("post_rst_idle", cnt, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en   = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 39) == 0);
            seed = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            taps = ($urandom_range(0, 1) != 0) ? DTAPS : (W'($urandom) | 7'h40);
            if ($urandom_range(0, 699) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        load = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
